// File: rtl/dmem_port_arbiter.sv
// Purpose : shares the single data block-RAM port between the CPU load/store path (requester 0)
//           and the graphics/DMA bypass path (requester 1).
// Latency : command on the RAM port 1 cycle after the request is sampled; read data and rvalidN 2 cycles after.
// Backpr. : requests are held until ackN; stall blocks new issue while read returns keep draining.
//
// Ports:
//   clk, rst          - system clock; synchronous active-low reset (0 = reset)
//   stall             - global stall, blocks new command issue
//   reqN/addrN/weN/dinN - requester N command (weN == 0 means read), held until ackN
//   ackN              - one-cycle pulse, requester N command accepted
//   rvalidN           - read data for requester N is on rdata this cycle
//   rdata             - shared read data, mem_dout passed straight through
//   mem_addr/mem_we/mem_re/mem_din - registered RAM command
//   mem_dout          - RAM read data, valid one cycle after the command is on the port

module dmem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 8     // 1..255: losing cycles before requester 1 is force-granted
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,

   input  logic              req0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [3:0]        we0,
   input  logic [31:0]       din0,
   output logic              ack0,
   output logic              rvalid0,

   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [3:0]        we1,
   input  logic [31:0]       din1,
   output logic              ack1,
   output logic              rvalid1,

   output logic [31:0]       rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_we,
   output logic              mem_re,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
   localparam logic [7:0] WAIT_SAT   = 8'hFF;

   // One record per issued command slot: was it a read, and who asked for it.
   typedef struct packed {
      logic vld;
      logic id;
   } tag_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_we_q,   mem_we_d;
   logic              mem_re_q,   mem_re_d;
   logic [31:0]       mem_din_q,  mem_din_d;
   logic              ack0_q,     ack0_d;
   logic              ack1_q,     ack1_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   tag_t              tag_s1_q,   tag_s1_d;   // read command currently on the RAM port
   tag_t              tag_s2_q,   tag_s2_d;   // read whose data is on mem_dout this cycle

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   logic elig0;
   logic elig1;
   logic aged;
   logic grant0;
   logic grant1;
   logic grant_rd;

   always_comb begin
      // A requester acked this cycle still shows its old request; masking it
      // stops the same command from being issued twice.
      elig0 = req0 & ~ack0_q;
      elig1 = req1 & ~ack1_q;
      aged  = (wait_cnt_q >= WAIT_LIMIT);

      // Requester 1 wins when it has waited long enough, or when 0 is not competing.
      grant1 = ~stall & elig1 & (aged | ~elig0);
      grant0 = ~stall & elig0 & ~grant1;

      grant_rd = (grant0 & (we0 == 4'b0000)) | (grant1 & (we1 == 4'b0000));
   end

   // ------------------------------------------------------------------
   // Command issue
   // ------------------------------------------------------------------
   always_comb begin
      // Address and write data hold when idle so the RAM inputs only toggle on real commands.
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 4'b0000;
      mem_re_d   = 1'b0;

      if (grant1) begin
         mem_addr_d = addr1;
         mem_din_d  = din1;
         mem_we_d   = we1;
         mem_re_d   = (we1 == 4'b0000);
      end else if (grant0) begin
         mem_addr_d = addr0;
         mem_din_d  = din0;
         mem_we_d   = we0;
         mem_re_d   = (we0 == 4'b0000);
      end

      ack0_d = grant0;
      ack1_d = grant1;
   end

   // ------------------------------------------------------------------
   // Read-return tag pipeline
   // ------------------------------------------------------------------
   always_comb begin
      // Keeps shifting during stall so reads already issued still return.
      tag_s1_d.vld = grant_rd;
      tag_s1_d.id  = grant1;
      tag_s2_d     = tag_s1_q;
   end

   // ------------------------------------------------------------------
   // Aging counter for requester 1
   // ------------------------------------------------------------------
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!stall) begin
         if (grant1 || !req1) begin
            wait_cnt_d = 8'd0;
         end else if (elig1 && grant0 && (wait_cnt_q != WAIT_SAT)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_addr_q <= '0;
         mem_we_q   <= 4'b0000;
         mem_re_q   <= 1'b0;
         mem_din_q  <= 32'd0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         wait_cnt_q <= 8'd0;
         tag_s1_q   <= '0;
         tag_s2_q   <= '0;
      end else begin
         mem_addr_q <= mem_addr_d;
         mem_we_q   <= mem_we_d;
         mem_re_q   <= mem_re_d;
         mem_din_q  <= mem_din_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         wait_cnt_q <= wait_cnt_d;
         tag_s1_q   <= tag_s1_d;
         tag_s2_q   <= tag_s2_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mem_addr = mem_addr_q;
   assign mem_we   = mem_we_q;
   assign mem_re   = mem_re_q;
   assign mem_din  = mem_din_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;

   assign rvalid0  = tag_s2_q.vld & ~tag_s2_q.id;
   assign rvalid1  = tag_s2_q.vld &  tag_s2_q.id;
   assign rdata    = mem_dout;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Purpose : self-checking bench for dmem_port_arbiter, one table vector per clock cycle.
// Latency : acks expected 1 cycle after each vector, read returns 2 cycles after.
// Backpr. : requesters hold req until ack and change it only after the ack cycle.

module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        req0, req1;
   logic [31:0] addr0, addr1;
   logic [3:0]  we0, we1;
   logic [31:0] din0, din1;
   logic        ack0, ack1;
   logic        rvalid0, rvalid1;
   logic [31:0] rdata;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic        mem_re;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = 32'd0;

   dmem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .req0(req0), .addr0(addr0), .we0(we0), .din0(din0), .ack0(ack0), .rvalid0(rvalid0),
      .req1(req1), .addr1(addr1), .we1(we1), .din1(din1), .ack1(ack1), .rvalid1(rvalid1),
      .rdata(rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   // RAM model: read data is a fixed function of the address, one cycle after the command.
   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   always @(posedge clk) begin
      if (mem_re === 1'b1) mem_dout <= ram_word(mem_addr);
   end

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        req0;
      logic [31:0] addr0;
      logic [3:0]  we0;
      logic [31:0] din0;
      logic        req1;
      logic [31:0] addr1;
      logic [3:0]  we1;
      logic [31:0] din1;
      logic        e_ack0;
      logic        e_ack1;
   } vec_t;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] data;
   } ret_t;

   vec_t vecs[$];
   ret_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add_vec(input logic rn, input logic st,
                          input logic r0, input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                          input logic r1, input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                          input logic ea0, input logic ea1);
      vec_t v;
      v.rst_n = rn;  v.stall = st;
      v.req0  = r0;  v.addr0 = a0; v.we0 = w0; v.din0 = d0;
      v.req1  = r1;  v.addr1 = a1; v.we1 = w1; v.din1 = d1;
      v.e_ack0 = ea0; v.e_ack1 = ea1;
      vecs.push_back(v);
   endtask

   task automatic idle_vec();
      add_vec(1, 0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      vec_t        v;
      ret_t        r;
      logic [31:0] exp_addr;
      logic [31:0] exp_din;
      logic [3:0]  e_we;
      logic        e_re;
      logic        e_rv0, e_rv1;

      rst = 1'b0; stall = 1'b0;
      req0 = 1'b0; addr0 = '0; we0 = '0; din0 = '0;
      req1 = 1'b0; addr1 = '0; we1 = '0; din1 = '0;

      // Reset held 3 cycles with a pending read from requester 0; ack follows release.
      for (int k = 0; k < 3; k++)
         add_vec(0, 0, 1, 32'h100, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
      add_vec(1, 0, 1, 32'h100, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h100, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
      idle_vec();
      // Byte write from requester 1: no read return.
      add_vec(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h40, 4'b0011, 32'hDEADBEEF, 0, 1);
      add_vec(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h40, 4'b0011, 32'hDEADBEEF, 0, 0);
      idle_vec();
      // Requester 0 holding req continuously is issued every other cycle.
      add_vec(1, 0, 1, 32'h200, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h200, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
      add_vec(1, 0, 1, 32'h200, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
      idle_vec();
      // Request raised under stall then withdrawn: nothing issues.
      add_vec(1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h300, 4'h0, 32'h0, 0, 0);
      idle_vec();
      // Read then 5 stall cycles: return still arrives, req1 waits for stall release.
      add_vec(1, 0, 1, 32'h500, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
      for (int k = 0; k < 5; k++)
         add_vec(1, 1, 0, 32'h0, 4'h0, 32'h0, 1, 32'h540, 4'h0, 32'h0, 0, 0);
      add_vec(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h540, 4'h0, 32'h0, 0, 1);
      add_vec(1, 0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h540, 4'h0, 32'h0, 0, 0);
      idle_vec();
      // Aging: stall between requester 0 writes keeps 0 eligible every live cycle,
      // so requester 1 only gets in once it has lost 8 times.
      for (int k = 0; k < 8; k++) begin
         add_vec(1, 0, 1, 32'h600 + 32'(4 * k), 4'hF, 32'h1111_0000 + 32'(k),
                 1, 32'h640, 4'h0, 32'h0, 1, 0);
         add_vec(1, 1, 1, 32'h600 + 32'(4 * k), 4'hF, 32'h1111_0000 + 32'(k),
                 1, 32'h640, 4'h0, 32'h0, 0, 0);
      end
      add_vec(1, 0, 1, 32'h620, 4'hF, 32'h1111_0009, 1, 32'h640, 4'h0, 32'h0, 0, 1);
      add_vec(1, 0, 1, 32'h620, 4'hF, 32'h1111_0009, 1, 32'h640, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h620, 4'hF, 32'h1111_0009, 0, 32'h0,   4'h0, 32'h0, 0, 0);
      idle_vec();
      // Interleaved reads, alternating winners, then reset mid-stream.
      add_vec(1, 0, 1, 32'h700, 4'h0, 32'h0, 1, 32'h780, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h700, 4'h0, 32'h0, 1, 32'h780, 4'h0, 32'h0, 0, 1);
      add_vec(1, 0, 1, 32'h704, 4'h0, 32'h0, 1, 32'h780, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h704, 4'h0, 32'h0, 1, 32'h784, 4'h0, 32'h0, 0, 1);
      add_vec(1, 0, 1, 32'h708, 4'h0, 32'h0, 1, 32'h784, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h708, 4'h0, 32'h0, 1, 32'h788, 4'h0, 32'h0, 0, 1);
      add_vec(0, 0, 1, 32'h70C, 4'h0, 32'h0, 1, 32'h788, 4'h0, 32'h0, 0, 0);
      add_vec(1, 0, 1, 32'h70C, 4'h0, 32'h0, 1, 32'h788, 4'h0, 32'h0, 1, 0);
      add_vec(1, 0, 1, 32'h70C, 4'h0, 32'h0, 1, 32'h788, 4'h0, 32'h0, 0, 1);
      idle_vec();
      idle_vec();

      exp_addr = 32'h0;
      exp_din  = 32'h0;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         rst   = v.rst_n; stall = v.stall;
         req0  = v.req0;  addr0 = v.addr0; we0 = v.we0; din0 = v.din0;
         req1  = v.req1;  addr1 = v.addr1; we1 = v.we1; din1 = v.din1;

         // Expected RAM command and read returns for this vector.
         e_we = 4'h0;
         e_re = 1'b0;
         if (!v.rst_n) begin
            sb.delete();
            exp_addr = 32'h0;
            exp_din  = 32'h0;
         end else if (v.e_ack0) begin
            exp_addr = v.addr0; exp_din = v.din0; e_we = v.we0; e_re = (v.we0 == 4'h0);
         end else if (v.e_ack1) begin
            exp_addr = v.addr1; exp_din = v.din1; e_we = v.we1; e_re = (v.we1 == 4'h0);
         end
         if (e_re) begin
            r.due  = i + 1;
            r.id   = v.e_ack1;
            r.data = ram_word(exp_addr);
            sb.push_back(r);
         end

         @(posedge clk);
         #1;

         e_rv0 = (sb.size() > 0) && (sb[0].due == i) && (sb[0].id == 1'b0);
         e_rv1 = (sb.size() > 0) && (sb[0].due == i) && (sb[0].id == 1'b1);

         chk($sformatf("v%0d.ack0", i),     {31'd0, ack0},    {31'd0, v.e_ack0});
         chk($sformatf("v%0d.ack1", i),     {31'd0, ack1},    {31'd0, v.e_ack1});
         chk($sformatf("v%0d.mem_re", i),   {31'd0, mem_re},  {31'd0, e_re});
         chk($sformatf("v%0d.mem_we", i),   {28'd0, mem_we},  {28'd0, e_we});
         chk($sformatf("v%0d.mem_addr", i), mem_addr,         exp_addr);
         chk($sformatf("v%0d.mem_din", i),  mem_din,          exp_din);
         chk($sformatf("v%0d.rvalid0", i),  {31'd0, rvalid0}, {31'd0, e_rv0});
         chk($sformatf("v%0d.rvalid1", i),  {31'd0, rvalid1}, {31'd0, e_rv1});
         if (e_rv0 || e_rv1) begin
            chk($sformatf("v%0d.rdata", i), rdata, sb[0].data);
            void'(sb.pop_front());
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data block-RAM port (CPU data side, Memory150 dcache port in CP2/CP3) between two requesters.
- Requester 0 is the CPU load/store path. Requester 1 is the graphics/DMA bypass path.
- Registered command issue, one-cycle-pulse acknowledge, tagged read-return routing.
- Fixed priority to requester 0, with an aging counter that guarantees requester 1 forward progress.

Parameters:
- ADDR_W, 32, address width.
- MAX_WAIT, 8, number of consecutive losing cycles after which requester 1 is force-granted. Legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset. Sampled on clk; 0 = reset.
- stall  in  1  global stall. While 1, no new command issues.
- req0  in  1  requester 0 request; held until ack0.
- addr0  in  ADDR_W  requester 0 byte address.
- we0  in  4  requester 0 byte write enables; 0000 = read.
- din0  in  32  requester 0 write data.
- ack0  out  1  one-cycle pulse: requester 0 command accepted.
- rvalid0  out  1  requester 0 read data valid.
- req1, addr1, we1, din1, ack1, rvalid1: same as above for requester 1.
- rdata  out  32  read data, shared by both requesters; qualified by rvalidN.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  4  RAM byte write enables (registered).
- mem_re  out  1  RAM read enable (registered).
- mem_din  out  32  RAM write data (registered).
- mem_dout  in  32  RAM read data; valid one cycle after the command is on the port.

Behaviour:
- Reset (rst=0 at an edge):
  - mem_addr, mem_we, mem_re, mem_din, ack0, ack1, rvalid0, rvalid1 = 0.
  - wait counter = 0; in-flight tag pipeline cleared.
  - Any in-flight read is discarded; no rvalid follows reset.
- Arbitration, evaluated every cycle t:
  - eligibleN = reqN & ~ackN. A requester acked in t is ineligible in t, which prevents re-issue of a held request.
  - Winner: if stall=1, none.
  - Else if eligible1 and wait_cnt >= MAX_WAIT, requester 1.
  - Else if eligible0, requester 0.
  - Else if eligible1, requester 1.
  - Else none.
- Issue (edge ending t):
  - With a winner: mem_addr/mem_we/mem_din take the winner's values; mem_re = (we==0); ackWinner = 1 in t+1.
  - With no winner: mem_we = 0, mem_re = 0. mem_addr and mem_din hold their previous values. Both acks = 0.
- Latency for a read sampled in t:
  - Command is on the port in t+1.
  - mem_dout is valid in t+2.
  - rvalidN = 1 in t+2 only; rdata = mem_dout passed through combinationally.
  - Writes produce no rvalid.
- Tag pipeline: a 2-stage shift of {valid, id} records each issued read so that rvalid routes to the correct requester. Back-to-back reads from alternating requesters return in order, one per cycle.
- Throughput:
  - One command per cycle overall.
  - A single requester holding req continuously is issued every other cycle, because of the ack/eligibility masking.
- Aging counter:
  - Increments (saturating at 255) each cycle in which eligible1=1, stall=0 and requester 0 wins.
  - Clears when requester 1 wins or req1=0.
  - Holds while stall=1.
- Stall:
  - No issue, no acks.
  - Tag pipeline and rvalid still advance, so reads issued before the stall still return.
- Simultaneous requests with wait_cnt < MAX_WAIT: requester 0 wins.
- Simultaneous requests with wait_cnt >= MAX_WAIT: requester 1 wins. Requester 0 wins the next eligible cycle.
- Requester protocol:
  - Requester sees ackN in t+1 and must drop or change reqN/addrN at the edge ending t+1.
  - Changing addr/we/din while req is high and unacked is illegal.
- Deasserting reqN before its ack: withdraws the request with no side effects; the aging counter clears if N=1.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req0=1 -> no ack0; mem_we=0, mem_re=0, all rvalid=0; first ack0 comes exactly 1 cycle after rst rises.
- Single read: req0=1, addr0=0x100, we0=0 at t -> mem_addr=0x100, mem_re=1, ack0=1 at t+1; rvalid0=1 at t+2 with rdata=mem_dout; rvalid1 stays 0.
- Write: req1=1, addr1=0x40, we1=4'b0011, din1=0xDEADBEEF -> t+1: mem_we=0011, mem_din=0xDEADBEEF, mem_re=0, ack1=1; no rvalid.
- Fairness: req0 and req1 both held high, MAX_WAIT=8 -> requester 1 granted no later than its 9th eligible cycle; the aging counter then clears.
- Stall: a read is issued at t, then stall=1 from t+1 to t+5 -> rvalid still at t+2; no acks during the stall; a pending req1 issues the cycle after stall drops.
- Interleave: alternating reads from req0 and req1 every cycle -> rvalid0/rvalid1 alternate at 2-cycle latency, each with the correct rdata. A mid-stream reset suppresses all pending rvalid.
